// File: rtl/proc_ldst_if.sv
// Instruction-source and memory-port bundle for proc_ldst.
// master = processor side, slave = instruction source plus memory.
interface proc_ldst_if #(
  parameter int unsigned DW = 9
);
  logic [DW-1:0] din;
  logic          run;
  logic          done;
  logic [DW-1:0] bus_wires;
  logic [DW-1:0] addr;
  logic [DW-1:0] dout;
  logic          mreq;
  logic          w;
  logic          mack;
  logic [DW-1:0] mdin;
  logic          z;
  logic          err;

  modport master (
    input  din, run, mack, mdin,
    output done, bus_wires, addr, dout, mreq, w, z, err
  );

  modport slave (
    output din, run, mack, mdin,
    input  done, bus_wires, addr, dout, mreq, w, z, err
  );
endinterface

// File: rtl/proc_ldst.sv
// Multi-cycle bus processor: R0..R7, A/G accumulator, step FSM T0..T3,
// with handshaked load/store, conditional move, AND, zero flag and memory timeout.
module proc_ldst #(
  parameter int unsigned DW      = 9,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  proc_ldst_if.master     bus_io
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  state_e               state_q, state_d;
  logic [8:0]           ir_q, ir_d;
  logic [7:0][DW-1:0]   r_q, r_d;
  logic [DW-1:0]        a_q, a_d;
  logic [DW-1:0]        g_q, g_d;
  logic [DW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 z_q, z_d;

  logic [2:0]           op, rx, ry;
  logic [DW-1:0]        alu_c, bus_c;
  logic                 done_c, mreq_c, w_c, err_c, tmo_c;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Counter already holds TIMEOUT-1 elapsed wait cycles, so this cycle is the TIMEOUT-th.
  assign tmo_c = (TIMEOUT != 0) && !bus_io.mack && (cnt_q == CNT_LAST);

  always_comb begin
    alu_c = '0;
    unique case (op)
      OP_ADD:  alu_c = a_q + r_q[ry];
      OP_SUB:  alu_c = a_q - r_q[ry];
      OP_AND:  alu_c = a_q & r_q[ry];
      default: alu_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    r_d     = r_q;
    a_d     = a_q;
    g_d     = g_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    bus_c   = '0;
    done_c  = 1'b0;
    mreq_c  = 1'b0;
    w_c     = 1'b0;
    err_c   = 1'b0;

    unique case (state_q)
      T0: begin
        if (bus_io.run) begin
          ir_d    = bus_io.din[8:0];
          state_d = T1;
        end
      end

      T1: begin
        unique case (op)
          OP_MV: begin
            bus_c     = r_q[ry];
            r_d[rx]   = r_q[ry];
            done_c    = 1'b1;
            state_d   = T0;
          end
          OP_MVI: begin
            bus_c     = bus_io.din;
            r_d[rx]   = bus_io.din;
            done_c    = 1'b1;
            state_d   = T0;
          end
          OP_MVNZ: begin
            bus_c     = r_q[ry];
            if (!z_q) r_d[rx] = r_q[ry];
            done_c    = 1'b1;
            state_d   = T0;
          end
          OP_LD, OP_ST: begin
            bus_c     = r_q[ry];
            addr_d    = r_q[ry];
            cnt_d     = '0;
            state_d   = T2;
          end
          default: begin
            bus_c     = r_q[rx];
            a_d       = r_q[rx];
            state_d   = T2;
          end
        endcase
      end

      T2: begin
        unique case (op)
          OP_LD: begin
            mreq_c = 1'b1;
            if (bus_io.mack) begin
              bus_c   = bus_io.mdin;
              r_d[rx] = bus_io.mdin;
              done_c  = 1'b1;
              state_d = T0;
            end else if (tmo_c) begin
              err_c   = 1'b1;
              done_c  = 1'b1;
              state_d = T0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end
          OP_ST: begin
            bus_c   = r_q[rx];
            dout_d  = r_q[rx];
            cnt_d   = '0;
            state_d = T3;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_c   = r_q[ry];
            g_d     = alu_c;
            z_d     = (alu_c == '0);
            state_d = T3;
          end
          default: state_d = T0;
        endcase
      end

      T3: begin
        unique case (op)
          OP_ST: begin
            mreq_c = 1'b1;
            w_c    = 1'b1;
            if (bus_io.mack) begin
              done_c  = 1'b1;
              state_d = T0;
            end else if (tmo_c) begin
              err_c   = 1'b1;
              done_c  = 1'b1;
              state_d = T0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_c   = g_q;
            r_d[rx] = g_q;
            done_c  = 1'b1;
            state_d = T0;
          end
          default: state_d = T0;
        endcase
      end

      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= T0;
      ir_q    <= '0;
      r_q     <= '0;
      a_q     <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      r_q     <= r_d;
      a_q     <= a_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign bus_io.bus_wires = bus_c;
  assign bus_io.done      = done_c;
  assign bus_io.mreq      = mreq_c;
  assign bus_io.w         = w_c;
  assign bus_io.err       = err_c;
  assign bus_io.addr      = addr_q;
  assign bus_io.dout      = dout_q;
  assign bus_io.z         = z_q;

endmodule

// File: doc/proc_ldst.md
Name: proc_ldst

Overview:
- Parametrised successor to the team's 9-bit multi-cycle bus processor.
- Eight general registers R0..R7, an A/G accumulator path, a shared BusWires bus and a step FSM.
- Generalised data width; adds load/store over a handshaked memory port, a conditional move, AND, a zero flag and a memory timeout.
- Sits between the instruction source (DIN/Run) and a memory or peripheral slave.

Parameters:
- DW, 9, data/register/bus/address width; legal range DW >= 9.
- TIMEOUT, 0, maximum number of cycles to wait for MAck; 0 disables the timeout.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- DIN  in  DW  instruction word in T0; immediate operand for mvi in T1.
- Run  in  1  starts an instruction; sampled in T0 only.
- Done  out  1  high for exactly one cycle, the final step of each instruction.
- BusWires  out  DW  internal bus value.
- ADDR  out  DW  registered memory address.
- DOUT  out  DW  registered store data.
- MReq  out  1  memory request; held until MAck or timeout.
- W  out  1  write qualifier; valid only while MReq is high.
- MAck  in  1  memory acknowledge; single-cycle completion.
- MDIN  in  DW  load data; valid in the cycle MAck is high.
- Z  out  1  zero flag.
- Err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset state: R0..R7, A, G, IR, ADDR, DOUT and the wait counter all clear to 0; Z=0; FSM to T0. Done, MReq, W and Err are all 0.
- Reset asserted mid-instruction: same effect immediately (asynchronous). MReq drops without waiting for MAck.
- Instruction fields are taken from DIN[8:0]: opcode I=IR[8:6], X=IR[5:3], Y=IR[2:0]. For DW>9, IR[DW-1:9] are ignored.
- FSM states: T0, T1, T2, T3.
  - T0: when Run=1, IR<=DIN and go to T1; otherwise stay in T0.
  - Run is ignored outside T0.
  - Every instruction returns to T0 in the cycle after Done.
- BusWires = 0 when no driver is selected.
- Opcode 000, mv: T1 bus=RY; RX<=bus; Done.
- Opcode 001, mvi: T1 bus=DIN; RX<=DIN; Done.
- Opcodes 010 add, 011 sub, 111 and:
  - T1: bus=RX, A<=bus.
  - T2: bus=RY; G<=A+RY, A-RY or A&RY, modulo 2^DW with carry/borrow discarded. Z<=(result==0).
  - T3: bus=G, RX<=G; Done.
- Opcode 110, mvnz:
  - T1: if Z==0, RX<=RY; otherwise no write.
  - Done in either case. Z is unchanged.
- Opcode 100, ld:
  - T1: bus=RY, ADDR<=RY.
  - T2: MReq=1, W=0; stay in T2 until MAck.
  - Cycle with MAck=1: bus=MDIN, RX<=MDIN, Done.
- Opcode 101, st:
  - T1: bus=RY, ADDR<=RY.
  - T2: bus=RX, DOUT<=RX.
  - T3: MReq=1, W=1; stay in T3 until MAck. Done in the MAck cycle.
- MReq/W are combinational from state; ADDR and DOUT are stable for the whole request.
- MAck while MReq=0 is ignored.
- Memory minimum latency: ld = 2 cycles after the T0 fetch cycle (ack in the first wait cycle); st = 3 cycles.
- Timeout (TIMEOUT>0):
  - The counter clears on entry to the wait state and increments each wait cycle without MAck.
  - The cycle the counter reaches TIMEOUT: Err=1 and Done=1, no register write, MReq deasserts on the next cycle, return to T0.
  - MAck arriving on that same cycle wins: normal completion, Err=0.
- X==Y is legal. add R1,R1 doubles R1; ld R2,[R2] overwrites the address register only after ADDR has been latched.
- Only add, sub and and update Z; mv, mvi, mvnz, ld and st leave it unchanged.

Test Plan:
1. Reset, then mvi R0 with DIN=9'b001000000 followed by DIN=9'd5, Run=1 -> R0=5, Done pulses in T1. Then mv R1,R0 -> R1=5.
2. R0=5, R1=5, sub R0,R1 (9'b011000001) -> G=0, Z=1, R0=0, Done in T3. Then mvnz R2,R1 -> R2 unchanged. Then add R0,R1 -> R0=5, Z=0; mvnz R2,R1 -> R2=5.
3. Wrap: R3=9'h1FF, R4=1, add R3,R4 -> R3=0, Z=1. Same values with and -> R3=1, Z=0.
4. st R1,[R4] with MAck delayed 3 cycles -> ADDR=1, DOUT=5, MReq=W=1 for 4 cycles, Done coincident with MAck. ld R5,[R4] with MDIN=9'h0AA and MAck in the first T2 cycle -> R5=0AA, W=0.
5. TIMEOUT=4, ld with MAck never asserted -> Err and Done pulse in the 4th wait cycle, RX unchanged, FSM in T0. Repeat with MAck on that same cycle -> normal load, Err=0.
6. Assert Reset during st T3 with MReq high -> MReq=0, all registers 0, FSM in T0 immediately. Next Run executes normally.
